// File: rtl/dfplayer_uart_cmd_tx.sv
// dfplayer_uart_cmd_tx: sends the DFPlayer init sequence, then user commands, as 10-byte 8N1 UART frames with inter-frame gaps.
module dfplayer_uart_cmd_tx #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int GAP_MS    = 20,
  parameter int INIT_VOL  = 30,
  parameter int INIT_EQ   = 0,
  parameter int INIT_MODE = 2,
  parameter int FEEDBACK  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd,
  input  logic [15:0] param,
  output logic        cmd_ready,
  output logic        tx,
  output logic        busy,
  output logic        init_done,
  output logic        frame_done
);
  localparam int DIV     = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int GAP_CYC = CLK_HZ / 1000 * GAP_MS;
  localparam int CW      = $clog2(DIV);
  localparam int GW      = $clog2(GAP_CYC);
  typedef enum logic [2:0] {INIT_LOAD, SHIFT, GAP, IDLE, LOAD} state_t;
  state_t state;
  logic [CW-1:0] bcnt;
  logic [GW-1:0] gcnt;
  logic [3:0] bit_i, byte_i, nbit, nbyte;
  logic [1:0] init_i;
  logic [7:0] c_r, nb;
  logic [15:0] p_r, ck;
  logic ntx;
  // tx is registered, so the next bit's level is prepared one bit-edge ahead
  always_comb begin
    ck = 16'h0000 - (16'h00FF + 16'h0006 + {8'h00, c_r} + 16'(FEEDBACK) + {8'h00, p_r[15:8]} + {8'h00, p_r[7:0]});
    nbit = bit_i == 4'd9 ? 4'd0 : bit_i + 4'd1;
    nbyte = bit_i == 4'd9 ? byte_i + 4'd1 : byte_i;
    case (nbyte)
      4'd0: nb = 8'h7E;
      4'd1: nb = 8'hFF;
      4'd2: nb = 8'h06;
      4'd3: nb = c_r;
      4'd4: nb = 8'(FEEDBACK);
      4'd5: nb = p_r[15:8];
      4'd6: nb = p_r[7:0];
      4'd7: nb = ck[15:8];
      4'd8: nb = ck[7:0];
      default: nb = 8'hEF;
    endcase
    ntx = nbit == 4'd0 ? 1'b0 : nbit == 4'd9 ? 1'b1 : nb[3'(nbit - 4'd1)];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT_LOAD;
      tx <= 1'b1;
      cmd_ready <= 1'b0;
      busy <= 1'b0;
      init_done <= 1'b0;
      frame_done <= 1'b0;
      init_i <= 2'd0;
      bcnt <= '0;
      gcnt <= '0;
      bit_i <= 4'd0;
      byte_i <= 4'd0;
      c_r <= 8'h00;
      p_r <= 16'h0000;
    end else begin
      frame_done <= 1'b0;
      case (state)
        INIT_LOAD, LOAD: begin
          if (state == INIT_LOAD) begin
            c_r <= 8'h06 + 8'(init_i);
            p_r <= {8'h00, init_i == 2'd0 ? 8'(INIT_VOL) : init_i == 2'd1 ? 8'(INIT_EQ) : 8'(INIT_MODE)};
          end
          tx <= 1'b0;
          bcnt <= '0;
          bit_i <= 4'd0;
          byte_i <= 4'd0;
          busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          if (bcnt == CW'(DIV - 1)) begin
            bcnt <= '0;
            if (byte_i == 4'd9 && bit_i == 4'd9) begin
              frame_done <= 1'b1;
              gcnt <= '0;
              tx <= 1'b1;
              state <= GAP;
            end else begin
              bit_i <= nbit;
              byte_i <= nbyte;
              tx <= ntx;
            end
          end else bcnt <= bcnt + CW'(1);
        end
        GAP: begin
          if (gcnt == GW'(GAP_CYC - 1)) begin
            if (!init_done && init_i != 2'd2) begin
              init_i <= init_i + 2'd1;
              state <= INIT_LOAD;
            end else begin
              init_done <= 1'b1;
              busy <= 1'b0;
              cmd_ready <= 1'b1;
              state <= IDLE;
            end
          end else gcnt <= gcnt + GW'(1);
        end
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            c_r <= cmd;
            p_r <= param;
            cmd_ready <= 1'b0;
            busy <= 1'b1;
            state <= LOAD;
          end
        end
        default: state <= INIT_LOAD;
      endcase
    end
  end
endmodule
